// File: rtl/elevator_car_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : elevator_car_ctrl                                            |
// | Description : Per-car SCAN elevator controller with owned pending stops.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module elevator_car_ctrl #(
  parameter int NUM_FLOORS    = 10,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16,
  parameter int TIMER_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req_set,
  input  logic                  door_hold,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  idle,
  output logic                  served_valid,
  output logic [FLOOR_W-1:0]    served_floor
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_MOVE       = 2'd1,
    S_DOOR_OPEN  = 2'd2,
    S_DOOR_CLOSE = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] c_travel_last = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_door_last   = TIMER_W'(DOOR_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic                    dir_q, dir_d;
  logic                    idle_q, idle_d;
  logic                    served_valid_q, served_valid_d;
  logic [FLOOR_W-1:0]      served_floor_q, served_floor_d;

  logic [NUM_FLOORS-1:0]   w_eff;
  logic [NUM_FLOORS-1:0]   w_clr;
  logic [FLOOR_W-1:0]      w_next_floor;
  logic                    w_at_cur, w_req_cur, w_at_next;
  logic                    w_ahead_up, w_ahead_dn, w_next_ahead;
  logic                    w_door_zone;

  always_comb begin
    w_eff        = pending_q | req_set;
    w_next_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    w_at_cur     = 1'b0;
    w_req_cur    = 1'b0;
    w_at_next    = 1'b0;
    w_ahead_up   = 1'b0;
    w_ahead_dn   = 1'b0;
    w_next_ahead = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (floor_q == FLOOR_W'(i)) begin
        w_at_cur  = w_at_cur | w_eff[i];
        w_req_cur = w_req_cur | req_set[i];
      end
      if (w_next_floor == FLOOR_W'(i)) w_at_next = w_at_next | w_eff[i];
      if (FLOOR_W'(i) > floor_q) w_ahead_up = w_ahead_up | w_eff[i];
      if (FLOOR_W'(i) < floor_q) w_ahead_dn = w_ahead_dn | w_eff[i];
      // "still ahead" is judged from the floor being arrived at, not the one left
      if (dir_q ? (FLOOR_W'(i) > w_next_floor) : (FLOOR_W'(i) < w_next_floor))
        w_next_ahead = w_next_ahead | w_eff[i];
    end

    state_d = state_q;
    timer_d = timer_q;
    floor_d = floor_q;
    dir_d   = dir_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (w_at_cur) begin
          state_d = S_DOOR_OPEN;
        end else if (dir_q ? w_ahead_up : w_ahead_dn) begin
          state_d = S_MOVE;
        end else if (dir_q ? w_ahead_dn : w_ahead_up) begin
          state_d = S_MOVE;
          dir_d   = ~dir_q;
        end
      end
      S_MOVE: begin
        if (timer_q == c_travel_last) begin
          timer_d = '0;
          floor_d = w_next_floor;
          if (w_at_next) state_d = S_DOOR_OPEN;
          else if (!w_next_ahead) state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_DOOR_OPEN: begin
        if (door_hold || w_req_cur) begin
          timer_d = '0;
        end else if (timer_q == c_door_last) begin
          timer_d = '0;
          state_d = S_DOOR_CLOSE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_DOOR_CLOSE: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase

    // served floor is cleared on the arrival edge and throughout dwell; clear wins over set
    w_door_zone = (state_q == S_DOOR_OPEN) || (state_d == S_DOOR_OPEN);
    w_clr       = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_clr[i] = w_door_zone && (floor_d == FLOOR_W'(i));
    end
    pending_d = w_eff & ~w_clr;

    served_valid_d = (state_d == S_DOOR_OPEN) && (state_q != S_DOOR_OPEN);
    served_floor_d = served_valid_d ? floor_d : served_floor_q;
    idle_d         = (state_d == S_IDLE) && (pending_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      pending_q      <= '0;
      floor_q        <= '0;
      dir_q          <= 1'b1;
      idle_q         <= 1'b1;
      served_valid_q <= 1'b0;
      served_floor_q <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      pending_q      <= pending_d;
      floor_q        <= floor_d;
      dir_q          <= dir_d;
      idle_q         <= idle_d;
      served_valid_q <= served_valid_d;
      served_floor_q <= served_floor_d;
    end
  end

  assign pending       = pending_q;
  assign current_floor = floor_q;
  assign direction     = dir_q;
  assign moving        = (state_q == S_MOVE);
  assign door_open     = (state_q == S_DOOR_OPEN);
  assign idle          = idle_q;
  assign served_valid  = served_valid_q;
  assign served_floor  = served_floor_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_elevator_car_ctrl                                         |
// | Description : Directed self-checking bench for elevator_car_ctrl.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_elevator_car_ctrl;

  localparam int NF = 10;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] req_set;
  logic          door_hold;
  logic [NF-1:0] pending;
  logic [FW-1:0] current_floor;
  logic          direction;
  logic          moving;
  logic          door_open;
  logic          idle;
  logic          served_valid;
  logic [FW-1:0] served_floor;

  int n_tests = 0;
  int n_fail  = 0;

  elevator_car_ctrl #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (8),
    .TIMER_W      (32)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_set      (req_set),
    .door_hold    (door_hold),
    .pending      (pending),
    .current_floor(current_floor),
    .direction    (direction),
    .moving       (moving),
    .door_open    (door_open),
    .idle         (idle),
    .served_valid (served_valid),
    .served_floor (served_floor)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_floor"}, 32'(current_floor), 32'd0);
    check({tag, "_dir"}, 32'(direction), 32'd1);
    check({tag, "_idle"}, 32'(idle), 32'd1);
    check({tag, "_pending"}, 32'(pending), 32'd0);
    check({tag, "_door"}, 32'(door_open), 32'd0);
    check({tag, "_moving"}, 32'(moving), 32'd0);
    check({tag, "_sv"}, 32'(served_valid), 32'd0);
  endtask

  // request visible for exactly one rising edge; returns just after that edge
  task automatic pulse_req(input logic [NF-1:0] mask);
    req_set = mask;
    @(posedge clk);
    #1 req_set = '0;
  endtask

  task automatic wait_served(input string tag, input int exp_floor, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (served_valid) break;
    end
    check({tag, "_valid"}, 32'(served_valid), 32'd1);
    check({tag, "_floor"}, 32'(served_floor), 32'(exp_floor));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle) break;
    end
    check({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  task automatic cycles_to_close(output int n, input int budget);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (!door_open) break;
    end
  endtask

  initial begin
    int cnt;
    rst       = 1'b1;
    req_set   = '0;
    door_hold = 1'b0;

    // reset
    repeat (2) @(negedge clk);
    check_reset("t1");
    rst = 1'b0;
    @(negedge clk);
    check("t1_idle_after", 32'(idle), 32'd1);

    // single trip 0 -> 3 with exact timing
    req_set = NF'(1 << 3);
    @(negedge clk);
    req_set = '0;
    check("t2_moving", 32'(moving), 32'd1);
    check("t2_dir", 32'(direction), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) @(negedge clk);
      check("t2_floor_hold", 32'(current_floor), 32'(k - 1));
      @(negedge clk);
      check("t2_floor_step", 32'(current_floor), 32'(k));
    end
    check("t2_sv", 32'(served_valid), 32'd1);
    check("t2_sf", 32'(served_floor), 32'd3);
    check("t2_door", 32'(door_open), 32'd1);
    check("t2_pending", 32'(pending), 32'd0);
    cnt = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) check("t2_sv_pulse", 32'(served_valid), 32'd0);
      cnt += int'(door_open);
    end
    check("t2_dwell", 32'(cnt), 32'd8);
    @(negedge clk);
    check("t2_close_door", 32'(door_open), 32'd0);
    check("t2_close_idle", 32'(idle), 32'd0);
    @(negedge clk);
    check("t2_idle", 32'(idle), 32'd1);
    check("t2_pending_end", 32'(pending), 32'd0);

    // move to 4, then request at the idle car's own floor
    pulse_req(NF'(1 << 4));
    wait_served("t5_pre", 4, 50);
    wait_idle("t5_pre", 50);
    pulse_req(NF'(1 << 4));
    check("t5_door", 32'(door_open), 32'd1);
    check("t5_floor", 32'(current_floor), 32'd4);
    check("t5_sv", 32'(served_valid), 32'd1);
    check("t5_sf", 32'(served_floor), 32'd4);
    check("t5_pending", 32'(pending), 32'd0);
    wait_idle("t5_post", 50);

    // door hold and re-open
    pulse_req(NF'(1 << 4));
    @(negedge clk);
    door_hold = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(door_open);
    end
    check("t4_held", 32'(cnt), 32'd20);
    door_hold = 1'b0;
    cycles_to_close(cnt, 40);
    check("t4_release", 32'(cnt), 32'd8);
    wait_idle("t4_mid", 50);
    pulse_req(NF'(1 << 4));
    repeat (3) @(negedge clk);
    req_set = NF'(1 << 4);
    @(negedge clk);
    req_set = '0;
    check("t4_reopen_door", 32'(door_open), 32'd1);
    check("t4_reopen_pending", 32'(pending), 32'd0);
    cycles_to_close(cnt, 40);
    check("t4_reopen", 32'(cnt), 32'd8);
    wait_idle("t4_post", 50);

    // SCAN: from 5 heading to 8, pick up 7 on the way, then reverse to 2
    pulse_req(NF'(1 << 5));
    wait_served("t3_pre", 5, 50);
    wait_idle("t3_pre", 50);
    pulse_req(NF'(1 << 8));
    repeat (2) @(negedge clk);
    req_set = NF'((1 << 2) | (1 << 7));
    @(negedge clk);
    req_set = '0;
    wait_served("t3_s7", 7, 100);
    check("t3_dir7", 32'(direction), 32'd1);
    wait_served("t3_s8", 8, 100);
    check("t3_dir8", 32'(direction), 32'd1);
    wait_served("t3_s2", 2, 100);
    check("t3_dir2", 32'(direction), 32'd0);
    check("t3_pending", 32'(pending), 32'd0);
    wait_idle("t3_post", 50);

    // reset mid-travel between 2 and 3
    pulse_req(NF'(1 << 3));
    repeat (2) @(negedge clk);
    check("t6_moving", 32'(moving), 32'd1);
    check("t6_floor", 32'(current_floor), 32'd2);
    check("t6_dir", 32'(direction), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("t6a");
    rst = 1'b0;

    // reset mid-dwell with another stop pending
    pulse_req(NF'(1 << 0));
    @(negedge clk);
    req_set = NF'(1 << 6);
    @(negedge clk);
    req_set = '0;
    check("t6_door", 32'(door_open), 32'd1);
    check("t6_pend6", 32'(pending), 32'h40);
    rst = 1'b1;
    @(negedge clk);
    check_reset("t6b");
    rst = 1'b0;

    // travel to both end floors
    pulse_req(NF'(1 << 9));
    wait_served("tb_top", 9, 100);
    wait_idle("tb_top", 50);
    check("tb_top_floor", 32'(current_floor), 32'd9);
    check("tb_top_dir", 32'(direction), 32'd1);
    pulse_req(NF'(1 << 0));
    wait_served("tb_bot", 0, 100);
    check("tb_bot_dir", 32'(direction), 32'd0);
    wait_idle("tb_bot", 50);
    check("tb_bot_floor", 32'(current_floor), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
